// File: rtl/combat_resolver.sv
// Per-frame hit resolution between the two players, plus hitstun, KO timing and round/match bookkeeping.
// Every decision is taken on the frame_tick cycle; all results are registered and appear one cycle later.
module combat_resolver #(
  parameter int MAX_HEALTH     = 5,
  parameter int DAMAGE         = 1,
  parameter int HITSTUN_FRAMES = 12,
  parameter int KO_FRAMES      = 90,
  parameter int ROUNDS_TO_WIN  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       p1_hit_active,
  input  logic       p2_hit_active,
  input  logic [9:0] p1_hit_x1,
  input  logic [9:0] p1_hit_x2,
  input  logic [9:0] p1_hit_y1,
  input  logic [9:0] p1_hit_y2,
  input  logic [9:0] p2_hit_x1,
  input  logic [9:0] p2_hit_x2,
  input  logic [9:0] p2_hit_y1,
  input  logic [9:0] p2_hit_y2,
  input  logic [9:0] p1_hurt_x1,
  input  logic [9:0] p1_hurt_x2,
  input  logic [9:0] p1_hurt_y1,
  input  logic [9:0] p1_hurt_y2,
  input  logic [9:0] p2_hurt_x1,
  input  logic [9:0] p2_hurt_x2,
  input  logic [9:0] p2_hurt_y1,
  input  logic [9:0] p2_hurt_y2,
  output logic [3:0] health1,
  output logic [3:0] health2,
  output logic       stun1,
  output logic       stun2,
  output logic       hit1,
  output logic       hit2,
  output logic [1:0] wins1,
  output logic [1:0] wins2,
  output logic       round_reset,
  output logic [1:0] state,
  output logic [1:0] winner
);

  // state | meaning
  // FIGHT | hits evaluated every frame; KO entered when a health reaches 0
  // KO    | KO countdown running; no hits; then next round or OVER
  // OVER  | match decided; everything frozen until rst
  typedef enum logic [1:0] {
    FIGHT = 2'd0,
    KO    = 2'd1,
    OVER  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] health1_q, health1_d, health2_q, health2_d;
  logic [5:0] stun_cnt1_q, stun_cnt1_d, stun_cnt2_q, stun_cnt2_d;
  logic [7:0] ko_cnt_q, ko_cnt_d;
  logic       latch1_q, latch1_d, latch2_q, latch2_d;
  logic       hit1_q, hit1_d, hit2_q, hit2_d;
  logic       round_reset_q, round_reset_d;
  logic [1:0] wins1_q, wins1_d, wins2_q, wins2_d;
  logic [1:0] winner_q, winner_d;
  logic       overlap1, overlap2, land1, land2;

  // Inclusive overlap; a box with inverted corners can never overlap anything.
  function automatic logic boxes_overlap(
    input logic [9:0] ax1, input logic [9:0] ax2, input logic [9:0] ay1, input logic [9:0] ay2,
    input logic [9:0] bx1, input logic [9:0] bx2, input logic [9:0] by1, input logic [9:0] by2
  );
    logic valid;
    valid = (ax1 <= ax2) && (ay1 <= ay2) && (bx1 <= bx2) && (by1 <= by2);
    return valid && (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
  endfunction

  assign overlap1 = boxes_overlap(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                                  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
  assign overlap2 = boxes_overlap(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                                  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);

  always_comb begin
    state_d       = state_q;
    health1_d     = health1_q;
    health2_d     = health2_q;
    stun_cnt1_d   = stun_cnt1_q;
    stun_cnt2_d   = stun_cnt2_q;
    ko_cnt_d      = ko_cnt_q;
    latch1_d      = latch1_q;
    latch2_d      = latch2_q;
    wins1_d       = wins1_q;
    wins2_d       = wins2_q;
    winner_d      = winner_q;
    hit1_d        = 1'b0;
    hit2_d        = 1'b0;
    round_reset_d = 1'b0;
    land1         = 1'b0;
    land2         = 1'b0;

    if (frame_tick && state_q != OVER) begin
      if (stun_cnt1_q != 6'd0) stun_cnt1_d = stun_cnt1_q - 6'd1;
      if (stun_cnt2_q != 6'd0) stun_cnt2_d = stun_cnt2_q - 6'd1;
      if (!p1_hit_active) latch1_d = 1'b0;
      if (!p2_hit_active) latch2_d = 1'b0;

      case (state_q)
        FIGHT: begin
          land1 = p1_hit_active && overlap1 && !latch1_q && (stun_cnt2_q == 6'd0);
          land2 = p2_hit_active && overlap2 && !latch2_q && (stun_cnt1_q == 6'd0);
          if (land1) begin
            health2_d   = (health2_q > 4'(DAMAGE)) ? health2_q - 4'(DAMAGE) : 4'd0;
            stun_cnt2_d = 6'(HITSTUN_FRAMES);
            latch1_d    = 1'b1;
            hit2_d      = 1'b1;
          end
          if (land2) begin
            health1_d   = (health1_q > 4'(DAMAGE)) ? health1_q - 4'(DAMAGE) : 4'd0;
            stun_cnt1_d = 6'(HITSTUN_FRAMES);
            latch2_d    = 1'b1;
            hit1_d      = 1'b1;
          end
          if (health1_d == 4'd0 || health2_d == 4'd0) begin
            state_d  = KO;
            ko_cnt_d = 8'(KO_FRAMES);
            if (health1_d == 4'd0 && health2_d == 4'd0) begin
              winner_d = 2'b11;
            end else if (health2_d == 4'd0) begin
              winner_d = 2'b01;
              wins1_d  = wins1_q + 2'd1;
            end else begin
              winner_d = 2'b10;
              wins2_d  = wins2_q + 2'd1;
            end
          end
        end
        KO: begin
          if (ko_cnt_q <= 8'd1) begin
            ko_cnt_d = 8'd0;
            if (wins1_q == 2'(ROUNDS_TO_WIN) || wins2_q == 2'(ROUNDS_TO_WIN)) begin
              state_d = OVER;
            end else begin
              state_d       = FIGHT;
              health1_d     = 4'(MAX_HEALTH);
              health2_d     = 4'(MAX_HEALTH);
              stun_cnt1_d   = 6'd0;
              stun_cnt2_d   = 6'd0;
              latch1_d      = 1'b0;
              latch2_d      = 1'b0;
              winner_d      = 2'b00;
              round_reset_d = 1'b1;
            end
          end else begin
            ko_cnt_d = ko_cnt_q - 8'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FIGHT;
      health1_q     <= 4'(MAX_HEALTH);
      health2_q     <= 4'(MAX_HEALTH);
      stun_cnt1_q   <= 6'd0;
      stun_cnt2_q   <= 6'd0;
      ko_cnt_q      <= 8'd0;
      latch1_q      <= 1'b0;
      latch2_q      <= 1'b0;
      hit1_q        <= 1'b0;
      hit2_q        <= 1'b0;
      round_reset_q <= 1'b0;
      wins1_q       <= 2'd0;
      wins2_q       <= 2'd0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      health1_q     <= health1_d;
      health2_q     <= health2_d;
      stun_cnt1_q   <= stun_cnt1_d;
      stun_cnt2_q   <= stun_cnt2_d;
      ko_cnt_q      <= ko_cnt_d;
      latch1_q      <= latch1_d;
      latch2_q      <= latch2_d;
      hit1_q        <= hit1_d;
      hit2_q        <= hit2_d;
      round_reset_q <= round_reset_d;
      wins1_q       <= wins1_d;
      wins2_q       <= wins2_d;
      winner_q      <= winner_d;
    end
  end

  assign health1     = health1_q;
  assign health2     = health2_q;
  assign stun1       = (stun_cnt1_q != 6'd0);
  assign stun2       = (stun_cnt2_q != 6'd0);
  assign hit1        = hit1_q;
  assign hit2        = hit2_q;
  assign wins1       = wins1_q;
  assign wins2       = wins2_q;
  assign round_reset = round_reset_q;
  assign state       = state_q;
  assign winner      = winner_q;

endmodule

// File: doc/combat_resolver.md
# combat_resolver

Per-frame hit resolution and round/match bookkeeping for the two-player fighter. Sits directly downstream of the two `player` instances, consuming their basic hit boxes and main hurt boxes. Produces health, hitstun, round-win and match state for the colour/HUD path and the player control gating. All decisions are taken once per game frame, on the `frame_tick` pulse.

## Interface
- `MAX_HEALTH`, 5: health loaded at reset and at each round start (1..15).
- `DAMAGE`, 1: health removed per landed hit.
- `HITSTUN_FRAMES`, 12: frames a struck player stays stunned (1..63).
- `KO_FRAMES`, 90: frames spent in KO before the next round or match end (1..255).
- `ROUNDS_TO_WIN`, 2: rounds needed to win the match (1..3).

- `clk` in 1: single clock, the `effective_clk` domain. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame; all evaluation happens only on this cycle.
- `p1_hit_active`, `p2_hit_active` in 1: attacker's hit box is live this frame.
- `p1_hit_x1/x2/y1/y2`, `p2_hit_x1/x2/y1/y2` in 10 each: inclusive hit-box corners.
- `p1_hurt_x1/x2/y1/y2`, `p2_hurt_x1/x2/y1/y2` in 10 each: inclusive hurt-box corners.
- `health1`, `health2` out 4: current health.
- `stun1`, `stun2` out 1: player is in hitstun; the controls of that player are masked.
- `hit1`, `hit2` out 1: one-cycle pulse when player N is struck.
- `wins1`, `wins2` out 2: rounds won.
- `round_reset` out 1: one-cycle pulse when a new round starts; players return to their spawn positions.
- `state` out 2: FIGHT=0, KO=1, OVER=2.
- `winner` out 2: 00 none, 01 P1, 10 P2, 11 draw (draw applies to the last round only).

## Operation
- Box validity: a box is invalid if x1>x2 or y1>y2. An invalid box never overlaps anything.
- Overlap test: `a.x1<=b.x2 && b.x1<=a.x2 && a.y1<=b.y2 && b.y1<=a.y2`, using 10-bit unsigned compares.
- Candidate hit by P1: `p1_hit_active`, P1 hit box overlaps P2 hurt box, `hit_latch1`=0, `stun2`=0, and state=FIGHT. The P2 case is symmetric.
- One hit per attack:
  - `hit_latchN` sets when a hit by player N lands.
  - It clears on any `frame_tick` where `pN_hit_active`=0.
- Landing a hit:
  - Victim health decreases by DAMAGE, saturating at 0.
  - Victim stun counter loads HITSTUN_FRAMES.
  - Victim `hitN` pulses.
- Trades: if P1 and P2 both land a hit in the same frame, both hits apply.
- Stun counters decrement on each `frame_tick` while nonzero. `stunN` = (counter != 0).
- State FIGHT:
  - After hits apply, if either health is 0 go to KO and load the KO counter with KO_FRAMES.
  - `winner` is set to the surviving player, or 11 if both are 0.
  - The round winner's `winsN` increments. On a draw, neither increments.
- State KO:
  - No hits are evaluated. The KO counter decrements on each `frame_tick`.
  - When the counter reaches 0: if either `winsN`==ROUNDS_TO_WIN go to OVER.
  - Otherwise go to FIGHT and, on that same cycle: health restored to MAX_HEALTH, stun counters and hit latches cleared, `winner`=00, `round_reset` pulsed.
- State OVER: all outputs hold until `rst`; `frame_tick` is ignored.

## Timing
- Reset values:
  - health1 = health2 = MAX_HEALTH.
  - stun1 = stun2 = 0; hit1 = hit2 = 0.
  - wins1 = wins2 = 0.
  - round_reset = 0; state = FIGHT; winner = 00.
  - Internal counters and latches = 0.
- All outputs are registered. Results of the `frame_tick` in cycle N are visible in cycle N+1.
- `hitN` and `round_reset` are high for exactly one cycle.
- Box inputs are sampled only on the `frame_tick` cycle. The inputs may change freely at all other times.
- A `frame_tick` held high for k cycles counts as k frames. Upstream guarantees single-cycle pulses.
- `rst` wins over `frame_tick` in the same cycle. `rst` asserted mid-KO or mid-stun returns everything to the reset values on the next edge.
- Health decrement, KO entry, win increment and `winner` update all land on the same edge.

## Test plan
- P1 box active and overlapping P2 hurt box for 5 consecutive frames, defaults → `health2` goes 5→4 once, `hit2` pulses once, `stun2` high for exactly 12 frames.
- Both attackers overlap the opposing hurt box on the same frame → health1=4 and health2=4, both `hit` pulse in the same cycle.
- P2 at health 1 takes a hit → next cycle health2=0, state=KO, winner=01, wins1=1. After 90 ticks: `round_reset` pulses, both healths =5, state=FIGHT, winner=00.
- Both players at health 1 trade a hit → winner=11, wins unchanged, KO entered, round replays after 90 frames.
- P1 wins a second round → state=OVER after the KO frames, `frame_tick` has no further effect, `rst` restores all reset values.
- Invalid hit box (x1=300, x2=200), active and positioned over the hurt box → no hit registered.
